// File: rtl/alu_ctrl.sv
// Command sequencer in front of the combinational ALU: 8x16 register file, operand issue, result writeback.
// Optional build macro ALU_CTRL_ZERO_R0_EN makes register 0 a hard-wired zero.
module alu_ctrl #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [2:0]  cmd_opcode,
  input  logic [2:0]  cmd_ra,
  input  logic [2:0]  cmd_rb,
  input  logic [2:0]  cmd_rd,
  input  logic        ld_valid,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_opcode,
  output logic        alu_mode,
  input  logic [31:0] alu_result,
  input  logic        alu_za,
  input  logic        alu_zb,
  input  logic        alu_eq,
  input  logic        alu_gt,
  input  logic        alu_lt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic [15:0] hi_reg,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam logic [1:0] CNT_LAST = 2'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic [1:0]  cnt_p0;
  logic [2:0]  rd_p0;
  logic [15:0] rf [8];

  function automatic logic [15:0] rf_read(input logic [2:0] idx);
`ifdef ALU_CTRL_ZERO_R0_EN
    return (idx == 3'd0) ? 16'h0000 : rf[idx];
`else
    return rf[idx];
`endif
  endfunction

  function automatic logic rf_wr_ok(input logic [2:0] idx);
`ifdef ALU_CTRL_ZERO_R0_EN
    return idx != 3'd0;
`else
    return (idx == idx);
`endif
  endfunction

  assign cmd_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign dbg_data  = rf_read(dbg_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt_p0     <= '0;
      rd_p0      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      alu_mode   <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      hi_reg     <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      // Load port first so a same-cycle writeback to the same index overrides it.
      if (ld_valid && rf_wr_ok(ld_addr)) rf[ld_addr] <= ld_data;
      case (state)
        // Issue stage: operands are captured from the register file at accept.
        IDLE: begin
          if (cmd_valid) begin
            alu_a      <= rf_read(cmd_ra);
            alu_b      <= rf_read(cmd_rb);
            alu_opcode <= cmd_opcode;
            alu_mode   <= cmd_mode;
            rd_p0      <= cmd_rd;
            cnt_p0     <= '0;
            state      <= EXEC;
          end
        end
        // Execute stage: ALU inputs held for ALU_LAT cycles, then result sampled.
        EXEC: begin
          if (cnt_p0 == CNT_LAST) begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_za, alu_zb, alu_eq, alu_gt, alu_lt};
            hi_reg     <= alu_result[31:16];
            if (rf_wr_ok(rd_p0)) rf[rd_p0] <= alu_result[15:0];
            state      <= RESP;
          end else begin
            cnt_p0 <= cnt_p0 + 2'd1;
          end
        end
        // Response stage: result and flags held until the consumer takes them.
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
